card_shoe: RTL and testbench

- Upstream card source for the baccarat datapath.
- Holds a shoe of DECKS standard decks, 13 ranks (1=Ace, 11..13=J/Q/K).
- Always pre-selects the next card, drawn pseudo-randomly without replacement, and presents it on new_card before any load_* pulse.
- The datapath latches new_card whenever the round state machine asserts a load_pcard*/load_dcard* strobe. Those six strobes are OR-ed into draw at top level.

---
 rtl/card_shoe.sv | 101 ++++++++++
 tb/tb_card_shoe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// card_shoe: multi-deck card source; presents ranks 1..13 drawn pseudo-randomly without replacement.
// Latency: draw -> next ready in 2..14 slow_clock cycles (1 PICK + 1..13 SCAN).
// Backpressure: card held on new_card while ready until draw; draws with ready=0 are dropped and flagged on draw_miss.
// Option: define CARD_SHOE_AUTO_RESHUFFLE_EN to refill the shoe on empty instead of halting.
module card_shoe #(
    parameter int         DECKS     = 1,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       draw,
    output logic [3:0] new_card,
    output logic       ready,
    output logic       shoe_empty,
    output logic [9:0] cards_left,
    output logic       draw_miss,
    output logic       reshuffled
);

    localparam logic [1:0] PICK  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] EMPTY = 2'd3;

    localparam logic [5:0] RANK_FULL = 6'(4 * DECKS);
    localparam logic [9:0] SHOE_FULL = 10'(52 * DECKS);

    logic [1:0] state;
    logic [7:0] lfsr;
    logic [3:0] cand;
    logic [3:0] cand_pick;
    logic [5:0] count [13:1];

    assign cand_pick  = 4'(lfsr % 8'd13) + 4'd1;
    assign shoe_empty = (state == EMPTY);

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
    assign reshuffled = (state == EMPTY);
`else
    assign reshuffled = 1'b0;
`endif

    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            state      <= PICK;
            lfsr       <= LFSR_SEED;
            cand       <= 4'd1;
            new_card   <= 4'd0;
            ready      <= 1'b0;
            cards_left <= SHOE_FULL;
            draw_miss  <= 1'b0;
            for (int r = 1; r <= 13; r++) begin
                count[r] <= RANK_FULL;
            end
        end else begin
            // x^8+x^6+x^5+x^4+1, free-running in every state
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            draw_miss <= draw && !ready;
            case (state)
                PICK: begin
                    if (cards_left == 10'd0) begin
                        new_card <= 4'd0;
                        state    <= EMPTY;
                    end else begin
                        cand  <= cand_pick;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (count[cand] != 6'd0) begin
                        new_card <= cand;
                        ready    <= 1'b1;
                        state    <= READY;
                    end else begin
                        cand <= (cand == 4'd13) ? 4'd1 : cand + 4'd1;
                    end
                end
                READY: begin
                    // new_card only ever names a rank with a non-zero count
                    if (draw) begin
                        count[new_card] <= count[new_card] - 6'd1;
                        cards_left      <= cards_left - 10'd1;
                        ready           <= 1'b0;
                        state           <= PICK;
                    end
                end
                EMPTY: begin
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
                    for (int r = 1; r <= 13; r++) begin
                        count[r] <= RANK_FULL;
                    end
                    cards_left <= SHOE_FULL;
                    state      <= PICK;
`endif
                end
                default: state <= PICK;
            endcase
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe (DECKS=1, seed 8'hA5); card order predicted from its own LFSR/shoe model.
module tb_card_shoe;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b1;
    logic       draw       = 1'b0;
    logic [3:0] new_card;
    logic       ready;
    logic       shoe_empty;
    logic [9:0] cards_left;
    logic       draw_miss;
    logic       reshuffled;

    int total = 0;
    int bad   = 0;
    int tally [1:13];
    int hist  [1:13];
    int left_m;
    int wraps = 0;
    logic [7:0] m_lfsr;

    card_shoe #(.DECKS(1), .LFSR_SEED(8'hA5)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .draw       (draw),
        .new_card   (new_card),
        .ready      (ready),
        .shoe_empty (shoe_empty),
        .cards_left (cards_left),
        .draw_miss  (draw_miss),
        .reshuffled (reshuffled)
    );

    always #5 slow_clock = ~slow_clock;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int cand_of(input logic [7:0] l);
        return int'(l % 8'd13) + 1;
    endfunction

    always @(posedge slow_clock or posedge resetb) begin
        if (resetb) m_lfsr <= 8'hA5;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    task automatic fill_model();
        for (int r = 1; r <= 13; r++) begin
            tally[r] = 4;
            hist[r]  = 0;
        end
        left_m = 52;
    endtask

    task automatic check_hist();
        for (int r = 1; r <= 13; r++) chk($sformatf("hist_rank%0d", r), 32'(hist[r]), 32'd4);
    endtask

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (ready !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
    endtask

    // Reset released at a falling edge: PICK samples 8'hA5 = 165 -> cand 10.
    task automatic release_and_check();
        @(negedge slow_clock);
        resetb = 1'b0;
        fill_model();
        tick();
        chk("first_pick_busy", 32'(ready), 32'd0);
        tick();
        chk("first_ready", 32'(ready), 32'd1);
        chk("first_card", 32'(new_card), 32'd10);
        chk("first_cards_left", 32'(cards_left), 32'd52);
        chk("first_not_empty", 32'(shoe_empty), 32'd0);
    endtask

    task automatic draw_one(input bit controlled, input bit dbl);
        int card, c, r, k, n, lat, left_after, non1_after, waited;
        bit ok;
        wait_ready();
        card = int'(new_card);
        ok = (card >= 1 && card <= 13) ? (tally[card] > 0) : 1'b0;
        chk("card_in_shoe", 32'(ok), 32'd1);
        if (ok) begin
            tally[card]--;
            hist[card]++;
        end
        left_after = left_m - 1;
        non1_after = left_after - tally[1];
        if (controlled) begin
            // Steer PICK onto live non-ace ranks; once only aces remain, force cand 13 to make SCAN wrap.
            waited = 0;
            ok = 1'b0;
            while (!ok && waited < 300) begin
                c = cand_of(lfsr_step(m_lfsr));
                if (left_after == 0)      ok = 1'b1;
                else if (non1_after == 0) ok = (c == 13);
                else                      ok = (c != 1) && (tally[c] > 0);
                if (!ok) begin
                    tick();
                    waited++;
                end
            end
            chk("cand_window", 32'(ok), 32'd1);
        end
        c = cand_of(lfsr_step(m_lfsr));
        draw = 1'b1;
        tick();
        n = 0;
        chk("ready_drop", 32'(ready), 32'd0);
        chk("cards_left_dec", 32'(cards_left), 32'(left_after));
        chk("no_miss_on_valid", 32'(draw_miss), 32'd0);
        if (dbl) begin
            tick();
            n = 1;
            chk("miss_on_second_draw", 32'(draw_miss), 32'd1);
            chk("cards_left_after_miss", 32'(cards_left), 32'(left_after));
        end
        draw = 1'b0;
        left_m = left_after;
        if (left_after == 0) return;
        r = c;
        k = 0;
        while (tally[r] == 0 && k < 13) begin
            r = (r == 13) ? 1 : r + 1;
            k++;
        end
        if (r < c) wraps++;
        lat = 2 + k;
        while (n < lat) begin
            chk("busy_while_scan", 32'(ready), 32'd0);
            tick();
            n++;
        end
        chk("ready_latency", 32'(ready), 32'd1);
        chk("card_predicted", 32'(new_card), 32'(r));
        if (dbl) chk("miss_one_cycle", 32'(draw_miss), 32'd0);
    endtask

    // Called right after the draw edge of the last card.
    task automatic check_empty();
        int c;
        tick();
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
        chk("empty_flag", 32'(shoe_empty), 32'd1);
        chk("reshuffled_pulse", 32'(reshuffled), 32'd1);
        chk("empty_ready", 32'(ready), 32'd0);
        chk("empty_cards_left", 32'(cards_left), 32'd0);
        c = cand_of(lfsr_step(m_lfsr));
        tick();
        chk("empty_one_cycle", 32'(shoe_empty), 32'd0);
        chk("reshuffled_one_cycle", 32'(reshuffled), 32'd0);
        chk("refill_cards_left", 32'(cards_left), 32'd52);
        tick();
        chk("refill_pick_busy", 32'(ready), 32'd0);
        tick();
        chk("refill_ready", 32'(ready), 32'd1);
        chk("refill_card", 32'(new_card), 32'(c));
        for (int r = 1; r <= 13; r++) tally[r] = 4;
        left_m = 52;
`else
        chk("empty_flag", 32'(shoe_empty), 32'd1);
        chk("empty_no_reshuffle", 32'(reshuffled), 32'd0);
        chk("empty_ready", 32'(ready), 32'd0);
        chk("empty_new_card", 32'(new_card), 32'd0);
        chk("empty_cards_left", 32'(cards_left), 32'd0);
        draw = 1'b1;
        tick();
        draw = 1'b0;
        chk("empty_draw_miss", 32'(draw_miss), 32'd1);
        chk("empty_draw_ignored", 32'(cards_left), 32'd0);
        tick();
        chk("empty_miss_one_cycle", 32'(draw_miss), 32'd0);
        chk("empty_is_terminal", 32'(shoe_empty), 32'd1);
        chk("empty_still_not_ready", 32'(ready), 32'd0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge slow_clock);
        chk("rst_new_card", 32'(new_card), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_shoe_empty", 32'(shoe_empty), 32'd0);
        chk("rst_cards_left", 32'(cards_left), 32'd52);
        chk("rst_draw_miss", 32'(draw_miss), 32'd0);
        chk("rst_reshuffled", 32'(reshuffled), 32'd0);

        // Steered drain: first draw doubled to hit PICK, then aces held back to force a 13 -> 1 wrap
        release_and_check();
        draw_one(1'b1, 1'b1);
        for (int i = 1; i < 52; i++) draw_one(1'b1, 1'b0);
        check_empty();
        check_hist();
        chk("scan_wrap_seen", 32'(wraps > 0), 32'd1);

        // 30 draws, then async reset while the 30th card is still in SCAN
        resetb = 1'b1;
        release_and_check();
        for (int i = 0; i < 29; i++) draw_one(1'b0, 1'b0);
        wait_ready();
        draw = 1'b1;
        tick();
        draw = 1'b0;
        tick();
        chk("pre_reset_in_scan", 32'(ready), 32'd0);
        #2 resetb = 1'b1;
        #1;
        chk("async_rst_new_card", 32'(new_card), 32'd0);
        chk("async_rst_ready", 32'(ready), 32'd0);
        chk("async_rst_cards_left", 32'(cards_left), 32'd52);
        chk("async_rst_shoe_empty", 32'(shoe_empty), 32'd0);

        // Free-running drain after reset proves all rank counts were restored
        release_and_check();
        for (int i = 0; i < 52; i++) draw_one(1'b0, 1'b0);
        check_empty();
        check_hist();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
